wb_bus_arbiter: RTL and testbench

- Shares one Wishbone classic slave port between N_MASTERS requesters, e.g. CPU instruction fetch (master 0) and data port (master 1) in front of the unified memory.
- Arbitration is round-robin and per-cycle: a grant is held for the whole Wishbone cycle, while the owner holds cyc.
- Slave responses (ack, err, rdata) are routed only to the granted master.

---
 rtl/selen_wb_pkg.sv | 22 ++
 rtl/wb_bus_arbiter_if.sv | 52 +++++
 rtl/wb_rr_picker.sv | 32 +++
 rtl/wb_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/selen_wb_pkg.sv
// Shared definitions for the Wishbone bus arbiter slice.
// Contents: arbiter state enum, default bus widths and the round-robin
// pointer increment helper.
package selen_wb_pkg;

    localparam int unsigned WB_ADDR_W = 32;
    localparam int unsigned WB_DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } wb_state_e;

    // Next round-robin position after idx, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end
        return idx + 32'd1;
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Bundle of the arbiter's master-side and slave-side Wishbone signals.
// Master side: m_cyc/m_stb/m_we/m_adr/m_wdat/m_sel in, m_ack/m_err/m_rdat out.
// Slave side:  s_cyc/s_stb/s_we/s_adr/s_wdat/s_sel out, s_ack/s_err/s_rdat in.
// Modports: master (requesters), slave (memory), arb (the arbiter itself).
interface wb_bus_arbiter_if
    import selen_wb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = WB_ADDR_W,
    parameter int unsigned DATA_W    = WB_DATA_W
) ();

    localparam int unsigned SEL_W = DATA_W / 8;

    logic [N_MASTERS-1:0]        m_cyc;
    logic [N_MASTERS-1:0]        m_stb;
    logic [N_MASTERS-1:0]        m_we;
    logic [N_MASTERS*ADDR_W-1:0] m_adr;
    logic [N_MASTERS*DATA_W-1:0] m_wdat;
    logic [N_MASTERS*SEL_W-1:0]  m_sel;
    logic [N_MASTERS-1:0]        m_ack;
    logic [N_MASTERS-1:0]        m_err;
    logic [DATA_W-1:0]           m_rdat;

    logic                        s_cyc;
    logic                        s_stb;
    logic                        s_we;
    logic [ADDR_W-1:0]           s_adr;
    logic [DATA_W-1:0]           s_wdat;
    logic [SEL_W-1:0]            s_sel;
    logic                        s_ack;
    logic                        s_err;
    logic [DATA_W-1:0]           s_rdat;

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_wdat, m_sel,
        input  m_ack, m_err, m_rdat
    );

    modport slave (
        input  s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel,
        output s_ack, s_err, s_rdat
    );

    modport arb (
        input  m_cyc, m_stb, m_we, m_adr, m_wdat, m_sel,
        output m_ack, m_err, m_rdat,
        output s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel,
        input  s_ack, s_err, s_rdat
    );

endinterface

// File: rtl/wb_rr_picker.sv
// Combinational round-robin priority encoder.
// Ports: req_i   request vector, one bit per master
//        ptr_i   index with highest priority this round
//        idx_o   first requester found scanning upward from ptr_i (wraps)
//        valid_o at least one request present
module wb_rr_picker #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned IDX_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 valid_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = int'(N_MASTERS) - 1; k >= 0; k--) begin
            cand = IDX_W'((32'(ptr_i) + 32'(k)) % N_MASTERS);
            if (req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave among N_MASTERS.
// A grant is taken in IDLE and held for the owner's whole cyc; slave
// responses are routed only to the owner. Bus muxing is combinational from
// the registered state/grant, so s_cyc follows m_cyc one cycle later.
// Ports: clk, rst (sync, active high), bus (wb_bus_arbiter_if.arb).
// Optional: define WB_BUS_ARBITER_TIMEOUT_EN to add a stall watchdog that
// errors the owner after TIMEOUT stalled strobe cycles and kills its cycle.
module wb_bus_arbiter
    import selen_wb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = WB_ADDR_W,
    parameter int unsigned DATA_W    = WB_DATA_W,
    parameter int unsigned TIMEOUT   = 255
) (
    input logic            clk,
    input logic            rst,
    wb_bus_arbiter_if.arb  bus
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned IDX_W = $clog2(N_MASTERS);

    if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_n
        $error("wb_bus_arbiter: N_MASTERS must be 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_bus_arbiter: TIMEOUT must be 1..65535");
    end

    wb_state_e        state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    logic [ADDR_W-1:0] adr_a  [N_MASTERS];
    logic [DATA_W-1:0] wdat_a [N_MASTERS];
    logic [SEL_W-1:0]  sel_a  [N_MASTERS];

    logic own_cyc, own_stb, own_we;
    logic busy, live;
    logic kill, to_pulse;

    // Unflatten per-master payloads so the owner can be selected by index.
    for (genvar i = 0; i < int'(N_MASTERS); i++) begin : g_unpack
        assign adr_a[i]  = bus.m_adr[i*ADDR_W +: ADDR_W];
        assign wdat_a[i] = bus.m_wdat[i*DATA_W +: DATA_W];
        assign sel_a[i]  = bus.m_sel[i*SEL_W +: SEL_W];
    end

    assign own_cyc = bus.m_cyc[grant_q];
    assign own_stb = bus.m_stb[grant_q];
    assign own_we  = bus.m_we[grant_q];
    assign busy    = (state_q == BUSY);
    // Owner still in its cycle and not killed by the watchdog.
    assign live    = busy && own_cyc && !kill;

    wb_rr_picker #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req_i   (bus.m_cyc),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Grant in IDLE, release when the owner drops cyc.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    ptr_d   = IDX_W'(rr_next(32'(grant_q), N_MASTERS));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Bus routing; responses during the release cycle are dropped via live.
    always_comb begin
        bus.s_cyc  = 1'b0;
        bus.s_stb  = 1'b0;
        bus.s_we   = 1'b0;
        bus.s_adr  = '0;
        bus.s_wdat = '0;
        bus.s_sel  = '0;
        bus.m_ack  = '0;
        bus.m_err  = '0;
        bus.m_rdat = '0;
        if (busy) begin
            bus.s_cyc  = live;
            bus.s_stb  = live && own_stb;
            bus.s_we   = own_we;
            bus.s_adr  = adr_a[grant_q];
            bus.s_wdat = wdat_a[grant_q];
            bus.s_sel  = sel_a[grant_q];
            bus.m_rdat = bus.s_rdat;
            bus.m_ack[grant_q] = bus.s_ack && live;
            bus.m_err[grant_q] = (bus.s_err && live) || to_pulse;
        end
    end

`ifdef WB_BUS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    logic [15:0] to_cnt_q, to_cnt_d;
    logic        to_flag_q, to_flag_d;

    // Single error pulse when the stall count hits the limit; the flag then
    // keeps the owner's slave cycle suppressed until it drops cyc.
    assign to_pulse = busy && own_cyc && !to_flag_q && (to_cnt_q == TO_LIMIT);
    assign kill     = to_flag_q || to_pulse;

    always_comb begin
        to_cnt_d  = to_cnt_q;
        to_flag_d = to_flag_q || to_pulse;
        if (!busy || !own_cyc) begin
            to_cnt_d  = '0;
            to_flag_d = 1'b0;
        end else if (bus.s_ack || bus.s_err) begin
            to_cnt_d = '0;
        end else if (own_stb && !kill) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end
`else
    assign to_pulse = 1'b0;
    assign kill     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter with two masters and TIMEOUT=8.
module tb_wb_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter_if #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bus ();

    wb_bus_arbiter #(
        .N_MASTERS (2),
        .ADDR_W    (32),
        .DATA_W    (32),
        .TIMEOUT   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit idx, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] wdat);
        if (idx) begin
            bus.m_cyc[1]       = cyc;
            bus.m_stb[1]       = stb;
            bus.m_we[1]        = we;
            bus.m_adr[63:32]   = adr;
            bus.m_wdat[63:32]  = wdat;
            bus.m_sel[7:4]     = 4'hC;
        end else begin
            bus.m_cyc[0]       = cyc;
            bus.m_stb[0]       = stb;
            bus.m_we[0]        = we;
            bus.m_adr[31:0]    = adr;
            bus.m_wdat[31:0]   = wdat;
            bus.m_sel[3:0]     = 4'hF;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bus.m_cyc  = '0;
        bus.m_stb  = '0;
        bus.m_we   = '0;
        bus.m_adr  = '0;
        bus.m_wdat = '0;
        bus.m_sel  = '0;
        bus.s_ack  = 1'b0;
        bus.s_err  = 1'b0;
        bus.s_rdat = 32'h1234_5678;
        step();
        step();
        settle();
        chk("rst_s_cyc", bus.s_cyc, 0);
        chk("rst_s_stb", bus.s_stb, 0);
        chk("rst_s_we", bus.s_we, 0);
        chk("rst_s_adr", bus.s_adr, 0);
        chk("rst_s_wdat", bus.s_wdat, 0);
        chk("rst_s_sel", bus.s_sel, 0);
        chk("rst_m_ack", bus.m_ack, 0);
        chk("rst_m_err", bus.m_err, 0);
        chk("rst_m_rdat", bus.m_rdat, 0);
        rst = 1'b0;

        // Single master 0 read, ack at cycle 3.
        drive(0, 1, 1, 0, 32'h0000_1000, 32'h0);
        settle();
        chk("t1_c0_s_cyc", bus.s_cyc, 0);
        step(); settle();
        chk("t1_c1_s_cyc", bus.s_cyc, 1);
        chk("t1_c1_s_stb", bus.s_stb, 1);
        chk("t1_c1_s_adr", bus.s_adr, 32'h0000_1000);
        chk("t1_c1_s_sel", bus.s_sel, 4'hF);
        step(); settle();
        chk("t1_c2_m_ack", bus.m_ack, 2'b00);
        step();
        bus.s_ack  = 1'b1;
        bus.s_rdat = 32'hDEAD_BEEF;
        settle();
        chk("t1_c3_m_ack", bus.m_ack, 2'b01);
        chk("t1_c3_m_rdat", bus.m_rdat, 32'hDEAD_BEEF);
        step();
        bus.s_ack = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        settle();
        chk("t1_rel_s_cyc", bus.s_cyc, 0);
        step(); settle();
        chk("t1_idle_s_cyc", bus.s_cyc, 0);

        // Simultaneous requests after reset, then round-robin hand-over.
        do_reset();
        drive(0, 1, 1, 0, 32'h0000_00A0, 32'h0);
        drive(1, 1, 1, 1, 32'h0000_00B0, 32'h0000_0055);
        step();
        bus.s_ack = 1'b1;
        settle();
        chk("t2_first_s_adr", bus.s_adr, 32'h0000_00A0);
        chk("t2_first_s_we", bus.s_we, 0);
        chk("t2_first_m_ack", bus.m_ack, 2'b01);
        step();
        bus.s_ack = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        settle();
        chk("t2_rel_s_cyc", bus.s_cyc, 0);
        step(); settle();
        chk("t2_gap_s_cyc", bus.s_cyc, 0);
        step();
        bus.s_ack = 1'b1;
        settle();
        chk("t2_second_s_cyc", bus.s_cyc, 1);
        chk("t2_second_s_adr", bus.s_adr, 32'h0000_00B0);
        chk("t2_second_s_we", bus.s_we, 1);
        chk("t2_second_s_wdat", bus.s_wdat, 32'h0000_0055);
        chk("t2_second_s_sel", bus.s_sel, 4'hC);
        chk("t2_second_m_ack", bus.m_ack, 2'b10);
        step();
        bus.s_ack = 1'b0;
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        step();
        drive(0, 1, 1, 0, 32'h0000_00A0, 32'h0);
        drive(1, 1, 1, 0, 32'h0000_00B0, 32'h0);
        step(); settle();
        chk("t2_third_s_cyc", bus.s_cyc, 1);
        chk("t2_third_s_adr", bus.s_adr, 32'h0000_00A0);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        step();
        step();

        // Held-cyc burst of 4 strobes by master 1 while master 0 waits.
        drive(1, 1, 1, 0, 32'h0000_0200, 32'h0);
        step();
        drive(0, 1, 1, 0, 32'h0000_0300, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            bus.m_adr[63:32] = 32'h0000_0200 + 32'(k);
            bus.s_ack = 1'b1;
            settle();
            chk("t3_burst_m_ack", bus.m_ack, 2'b10);
            chk("t3_burst_s_adr", bus.s_adr, 64'(32'h0000_0200 + 32'(k)));
        end
        step();
        bus.s_ack = 1'b0;
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        settle();
        chk("t3_rel_s_cyc", bus.s_cyc, 0);
        chk("t3_rel_m_ack", bus.m_ack, 2'b00);
        step(); settle();
        chk("t3_gap_s_cyc", bus.s_cyc, 0);
        step(); settle();
        chk("t3_m0_s_cyc", bus.s_cyc, 1);
        chk("t3_m0_s_adr", bus.s_adr, 32'h0000_0300);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        step();
        step();

        // Abort: owner drops cyc in the same cycle the slave acks.
        drive(1, 1, 1, 0, 32'h0000_0400, 32'h0);
        step(); settle();
        chk("t4_s_cyc", bus.s_cyc, 1);
        step();
        bus.s_ack = 1'b1;
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        settle();
        chk("t4_abort_m_ack", bus.m_ack, 2'b00);
        chk("t4_abort_s_cyc", bus.s_cyc, 0);
        step();
        bus.s_ack = 1'b0;
        settle();
        chk("t4_idle_s_cyc", bus.s_cyc, 0);

        // ack and err together are both forwarded to the owner.
        drive(0, 1, 1, 0, 32'h0000_0500, 32'h0);
        step();
        bus.s_ack = 1'b1;
        bus.s_err = 1'b1;
        settle();
        chk("t4b_s_adr", bus.s_adr, 32'h0000_0500);
        chk("t4b_m_ack", bus.m_ack, 2'b01);
        chk("t4b_m_err", bus.m_err, 2'b01);
        step();
        bus.s_ack = 1'b0;
        bus.s_err = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        step();

        // Reset in the middle of a master 1 write.
        drive(1, 1, 1, 1, 32'h0000_0600, 32'h0000_CAFE);
        step(); settle();
        chk("t5_s_cyc", bus.s_cyc, 1);
        chk("t5_s_we", bus.s_we, 1);
        chk("t5_s_adr", bus.s_adr, 32'h0000_0600);
        rst = 1'b1;
        step();
        bus.s_ack = 1'b1;
        settle();
        chk("t5_rst_s_cyc", bus.s_cyc, 0);
        chk("t5_rst_m_ack", bus.m_ack, 2'b00);
        rst = 1'b0;
        bus.s_ack = 1'b0;
        drive(0, 1, 1, 0, 32'h0000_0700, 32'h0);
        step(); settle();
        chk("t5_ptr0_s_cyc", bus.s_cyc, 1);
        chk("t5_ptr0_s_adr", bus.s_adr, 32'h0000_0700);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        step();
        step();

        // Stalled slave: master 1 strobes, slave never responds.
        drive(1, 1, 1, 0, 32'h0000_0800, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            step(); settle();
            chk("t6_stall_s_cyc", bus.s_cyc, 1);
            chk("t6_stall_m_err", bus.m_err, 2'b00);
        end
        step(); settle();
`ifdef WB_BUS_ARBITER_TIMEOUT_EN
        chk("t6_to_m_err", bus.m_err, 2'b10);
        chk("t6_to_s_cyc", bus.s_cyc, 0);
        chk("t6_to_s_stb", bus.s_stb, 0);
`else
        chk("t6_noto_m_err", bus.m_err, 2'b00);
        chk("t6_noto_s_cyc", bus.s_cyc, 1);
`endif
        step(); settle();
`ifdef WB_BUS_ARBITER_TIMEOUT_EN
        chk("t6_after_m_err", bus.m_err, 2'b00);
        chk("t6_after_s_cyc", bus.s_cyc, 0);
`else
        chk("t6_hold_m_err", bus.m_err, 2'b00);
        chk("t6_hold_s_cyc", bus.s_cyc, 1);
`endif
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        settle();
        chk("t6_rel_s_cyc", bus.s_cyc, 0);
        step(); settle();
        chk("t6_idle_s_cyc", bus.s_cyc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
